// File: rtl/stopwatch_time_ctrl_if.sv
// Control/status bundle between the stopwatch FSM controller (master) and the time datapath (slave).
interface stopwatch_time_ctrl_if;
  // All controls are plain levels sampled on every rising clk edge; there is no valid/ready
  // handshake, and the status outputs are always meaningful outside reset.
  logic        running;
  logic        lap;
  logic        clear;
  logic [1:0]  display_select;
  logic        tick;
  logic [23:0] disp_time;
  logic [1:0]  lap_valid;
  logic        overflow;

  modport master (
    output running, lap, clear, display_select,
    input  tick, disp_time, lap_valid, overflow
  );

  modport slave (
    input  running, lap, clear, display_select,
    output tick, disp_time, lap_valid, overflow
  );
endinterface

// File: rtl/stopwatch_time_ctrl.sv
// Stopwatch time datapath: gated centisecond prescaler, BCD mm:ss.cc counter,
// two alternating lap slots and a registered display word.
module stopwatch_time_ctrl #(
  parameter int DIV_COUNT = 500000,
  parameter int PRE_W     = 19
) (
  input  logic                 clk,
  input  logic                 rstn,
  stopwatch_time_ctrl_if.slave bus
);

  logic [PRE_W-1:0] pre_cnt;
  logic [23:0]      time_q;
  logic [23:0]      slot0;
  logic [23:0]      slot1;
  logic             lap_ptr;
  logic [1:0]       lap_valid_q;
  logic             overflow_q;
  logic [23:0]      disp_q;
  logic             lap_q;

  logic             tick;
  logic             lap_cap;
  logic             clear_act;
  logic [23:0]      time_inc;
  logic             time_wrap;
  logic             carry;
  logic [23:0]      disp_next;

  assign tick      = bus.running && (pre_cnt == PRE_W'(DIV_COUNT - 1));
  assign lap_cap   = bus.lap && !lap_q && bus.running;
  assign clear_act = bus.clear && !bus.running;

  // Ripple a +1 through the six BCD digits; tens-of-seconds and tens-of-minutes stop at 5.
  always_comb begin
    time_inc = time_q;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (time_q[i*4 +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
          time_inc[i*4 +: 4] = 4'd0;
        end else begin
          time_inc[i*4 +: 4] = time_q[i*4 +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    time_wrap = carry;
  end

  always_comb begin
    disp_next = time_q;
    case (bus.display_select)
      2'b01:   disp_next = lap_valid_q[0] ? slot0 : 24'h0;
      2'b10:   disp_next = lap_valid_q[1] ? slot1 : 24'h0;
      default: disp_next = time_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt     <= '0;
      time_q      <= '0;
      slot0       <= '0;
      slot1       <= '0;
      lap_ptr     <= 1'b0;
      lap_valid_q <= '0;
      overflow_q  <= 1'b0;
      disp_q      <= '0;
      lap_q       <= 1'b0;
    end else begin
      lap_q  <= bus.lap;
      disp_q <= disp_next;
      if (clear_act) begin
        pre_cnt     <= '0;
        time_q      <= '0;
        slot0       <= '0;
        slot1       <= '0;
        lap_ptr     <= 1'b0;
        lap_valid_q <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (bus.running) begin
          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
        // Capture samples the pre-increment time even when a tick lands on the same edge.
        if (lap_cap) begin
          if (lap_ptr) slot1 <= time_q;
          else         slot0 <= time_q;
          lap_valid_q[lap_ptr] <= 1'b1;
          lap_ptr              <= ~lap_ptr;
        end
        if (tick) begin
          time_q <= time_inc;
          if (time_wrap) overflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.tick      = tick;
  assign bus.disp_time = disp_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_time_ctrl.sv
// Bench for stopwatch_time_ctrl: directed scenarios plus random controls, checked every
// cycle against a centisecond-integer model of the stopwatch.
module tb_stopwatch_time_ctrl;
  localparam int DIV = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  stopwatch_time_ctrl_if bus();

  stopwatch_time_ctrl #(.DIV_COUNT(DIV), .PRE_W(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: time kept as an integer number of centiseconds, laps likewise.
  int          m_pre;
  int          m_cs;
  int          m_slot[2];
  int          m_ptr;
  bit [1:0]    m_valid;
  bit          m_ovf;
  bit          m_lap_q;
  bit          m_last_tick;
  logic [23:0] m_disp;

  function automatic logic [23:0] to_bcd(int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_pre = 0; m_cs = 0; m_slot[0] = 0; m_slot[1] = 0; m_ptr = 0;
    m_valid = 2'b00; m_ovf = 1'b0; m_lap_q = 1'b0; m_last_tick = 1'b0; m_disp = 24'h0;
  endtask

  task automatic model_edge();
    bit t, cap;
    logic [23:0] nd;
    t   = bus.running && (m_pre == DIV - 1);
    cap = bus.lap && !m_lap_q && bus.running;
    case (bus.display_select)
      2'b01:   nd = m_valid[0] ? to_bcd(m_slot[0]) : 24'h0;
      2'b10:   nd = m_valid[1] ? to_bcd(m_slot[1]) : 24'h0;
      default: nd = to_bcd(m_cs);
    endcase
    if (bus.clear && !bus.running) begin
      m_pre = 0; m_cs = 0; m_slot[0] = 0; m_slot[1] = 0; m_ptr = 0; m_valid = 2'b00; m_ovf = 1'b0;
    end else begin
      if (bus.running) m_pre = (m_pre + 1) % DIV;
      if (cap) begin
        m_slot[m_ptr]  = m_cs;
        m_valid[m_ptr] = 1'b1;
        m_ptr          = 1 - m_ptr;
      end
      if (t) begin
        if (m_cs == 359999) begin
          m_cs  = 0;
          m_ovf = 1'b1;
        end else begin
          m_cs = m_cs + 1;
        end
      end
    end
    m_lap_q     = bus.lap;
    m_disp      = nd;
    m_last_tick = t;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous compare, away from the active edge.
  always @(negedge clk) begin
    if (rstn && chk_en) begin
      check("tick",      32'(bus.tick),      32'(bus.running && (m_pre == DIV - 1)));
      check("disp_time", 32'(bus.disp_time), 32'(m_disp));
      check("lap_valid", 32'(bus.lap_valid), 32'(m_valid));
      check("overflow",  32'(bus.overflow),  32'(m_ovf));
    end
  end

  // One clock: model follows the edge, inputs may change 2 time units later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic run_until(int cs, int pre);
    int k = 0;
    while (!(m_cs == cs && (pre < 0 || m_pre == pre)) && k < 400) begin
      cyc();
      k++;
    end
    if (k >= 400) check("run_until_timeout", 32'(m_cs), 32'(cs));
  endtask

  task automatic run_to_tick();
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!m_last_tick && k < 16);
    if (!m_last_tick) check("tick_timeout", 32'(0), 32'(1));
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_tick",      32'(bus.tick),      32'(0));
    check("rst_disp",      32'(bus.disp_time), 32'(0));
    check("rst_lap_valid", 32'(bus.lap_valid), 32'(0));
    check("rst_overflow",  32'(bus.overflow),  32'(0));
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    bus.running = 1'b0; bus.lap = 1'b0; bus.clear = 1'b0; bus.display_select = 2'b00;
    model_reset();
    #1 rstn = 1'b0;
    #2;
    check("por_disp",      32'(bus.disp_time), 32'(0));
    check("por_lap_valid", 32'(bus.lap_valid), 32'(0));
    check("por_overflow",  32'(bus.overflow),  32'(0));
    @(posedge clk);
    #2 rstn = 1'b1;
    chk_en = 1'b1;

    // 1: free run, tenth tick shows as 00:00.10
    bus.running = 1'b1;
    repeat (41) cyc();
    check("s1_disp_10", 32'(bus.disp_time), 32'h000010);

    // 2: wrap from 59:59.98
    bus.running = 1'b0;
    cyc();
    dut.time_q = 24'h595998;
    m_cs       = 359998;
    bus.running = 1'b1;
    run_to_tick();
    cyc();
    check("s2_disp_595999", 32'(bus.disp_time), 32'h595999);
    run_to_tick();
    cyc();
    check("s2_disp_wrap", 32'(bus.disp_time), 32'h000000);
    check("s2_overflow",  32'(bus.overflow),  32'(1));
    repeat (10) cyc();
    check("s2_overflow_sticky", 32'(bus.overflow), 32'(1));

    // 3: held lap gives one capture, alternate slots, third overwrites slot0
    bus.running = 1'b0; bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    check("s3_overflow_cleared", 32'(bus.overflow), 32'(0));
    bus.running = 1'b1;
    run_until(5, -1);
    bus.lap = 1'b1;
    repeat (3) cyc();
    bus.lap = 1'b0;
    cyc();
    check("s3_one_capture", 32'(bus.lap_valid), 32'h1);
    run_until(9, -1);
    bus.lap = 1'b1;
    cyc();
    bus.lap = 1'b0;
    bus.display_select = 2'b01;
    cyc();
    check("s3_slot0", 32'(bus.disp_time), 32'h000005);
    bus.display_select = 2'b10;
    cyc();
    check("s3_slot1",      32'(bus.disp_time), 32'h000009);
    check("s3_lap_valid",  32'(bus.lap_valid), 32'h3);
    bus.lap = 1'b1;
    cyc();
    bus.lap = 1'b0;
    cyc();
    check("s3_slot1_kept", 32'(bus.disp_time), 32'h000009);
    bus.display_select = 2'b00;

    // 4: lap edge coincident with a tick at 00:00.07
    bus.running = 1'b0; bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0; bus.running = 1'b1;
    run_until(7, DIV - 1);
    bus.lap = 1'b1;
    cyc();
    bus.lap = 1'b0;
    bus.display_select = 2'b01;
    cyc();
    check("s4_lap_pre_inc", 32'(bus.disp_time), 32'h000007);
    bus.display_select = 2'b00;
    cyc();
    check("s4_live_post_inc", 32'(bus.disp_time), 32'h000008);

    // 5: clear ignored while running, honoured when stopped
    run_until(12, 1);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0; bus.running = 1'b0;
    cyc();
    cyc();
    check("s5_no_clear_disp", 32'(bus.disp_time), 32'h000012);
    check("s5_no_clear_lap",  32'(bus.lap_valid), 32'h1);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    cyc();
    check("s5_clear_disp",  32'(bus.disp_time), 32'h0);
    check("s5_clear_lap",   32'(bus.lap_valid), 32'h0);
    check("s5_clear_ovf",   32'(bus.overflow),  32'h0);
    bus.display_select = 2'b01;
    cyc();
    check("s5_empty_slot0", 32'(bus.disp_time), 32'h0);
    bus.display_select = 2'b00;

    // 6: partial period survives a stop; async reset mid-run
    bus.running = 1'b1;
    run_until(0, 2);
    bus.running = 1'b0;
    repeat (20) cyc();
    check("s6_stopped_tick", 32'(bus.tick), 32'(0));
    bus.running = 1'b1;
    #1;
    check("s6_resume_no_tick", 32'(bus.tick), 32'(0));
    cyc();
    check("s6_first_tick", 32'(bus.tick), 32'(1));
    repeat (5) cyc();
    reset_pulse();

    // Random controls
    for (int i = 0; i < 3000; i++) begin
      bus.running        = ($urandom_range(0, 7) != 0);
      bus.lap            = ($urandom_range(0, 4) == 0);
      bus.clear          = ($urandom_range(0, 9) == 0);
      bus.display_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) reset_pulse();
      cyc();
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
